// File: rtl/rfile_transmitter.sv
// rfile_transmitter: sweeps the 4x4 register file onto a serial link, one
// 7-bit packet {start, addr[1:0], data[3:0]} per register, MSB first.
module rfile_transmitter #(
    parameter int unsigned GAP = 0
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic [3:0] rfdata,
    output logic [1:0] rfaddr,
    output logic       link,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, SEND, GAPW} phase_t;

    localparam logic [2:0] GAP_W = 3'(GAP);

    phase_t     r_phase;
    logic [2:0] r_pcnt;
    logic [2:0] r_bcnt;
    logic [2:0] r_gcnt;
    logic [6:0] r_buf;
    logic       r_done;
    logic       w_eop;
    logic       w_load;

    assign rfaddr = r_pcnt[1:0];
    assign busy   = r_phase != IDLE;
    assign link   = r_phase == SEND && r_buf[6];
    assign done   = r_done;

    // With no gap the next start bit directly follows d0 of the previous packet
    assign w_eop  = r_phase == SEND && r_bcnt == 3'd7;
    assign w_load = (r_phase == IDLE && start)
                 || (w_eop && r_pcnt != 3'd4 && GAP_W == 3'd0)
                 || (r_phase == GAPW && r_gcnt == GAP_W);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_phase <= IDLE;
            r_pcnt  <= '0;
            r_bcnt  <= '0;
            r_gcnt  <= '0;
            r_buf   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_eop && r_pcnt == 3'd4;
            if (w_load) begin
                r_buf   <= {1'b1, rfaddr, rfdata};
                r_pcnt  <= r_pcnt + 3'd1;
                r_bcnt  <= 3'd1;
                r_phase <= SEND;
            end else if (w_eop) begin
                r_phase <= r_pcnt == 3'd4 ? IDLE : GAPW;
                r_pcnt  <= r_pcnt == 3'd4 ? 3'd0 : r_pcnt;
                r_gcnt  <= 3'd1;
            end else if (r_phase == SEND) begin
                r_buf  <= {r_buf[5:0], 1'b0};
                r_bcnt <= r_bcnt + 3'd1;
            end else if (r_phase == GAPW) begin
                r_gcnt <= r_gcnt + 3'd1;
            end
        end
    end
endmodule

// File: doc/rfile_transmitter.md
Name: rfile_transmitter

Overview:
- Serial sender that reads the 4-entry x 4-bit register file and sends every register over the serial link.
- Each register goes out as one packet: start bit, 2-bit address, 4-bit data, MSB first.
- Sits on the register-file side as the far end of the link into the register-file receiver, so the receiving side can mirror the file.
- One start pulse sends all four registers (a "sweep"), addresses 0 to 3, in that order.

Parameters:
GAP, 0, number of idle cycles (link=0) between consecutive packets of one sweep; legal range 0..7

Ports:
clock  input  1  system clock, all state updates on posedge
clear  input  1  synchronous active-high reset; when high, all state returns to idle
start  input  1  request one full sweep; sampled only when idle
rfdata input  4  read data from register file (combinational read of rfaddr)
rfaddr output 2  read address to register file, = next register to load
link   output 1  serial link output
busy   output 1  1 while a sweep is in progress
done   output 1  one-cycle pulse: sweep finished

Behaviour:
- Phases: IDLE, SEND, GAPW. Also a bit counter bcnt (1..7), a packet counter pcnt (0..4), a gap counter and a 7-bit shift buffer.
- rfaddr = pcnt[1:0], combinational.
- busy = (phase != IDLE).
- link = buffer[6] when phase == SEND, else 0.
- Reset (clear=1 at an edge):
  - phase=IDLE, pcnt=0, bcnt=0, buffer=0, done=0.
  - Hence link=0, busy=0, rfaddr=0 in the following cycle.
  - Clear overrides start and any in-flight packet; a partial packet is truncated, with no completion.
- Load event, at an edge:
  - buffer <= {1'b1, rfaddr, rfdata}; pcnt <= pcnt+1; bcnt <= 1; phase <= SEND.
  - Data is snapshotted at the load edge. Register-file writes after that edge do not affect the packet in flight; writes before it do.
- IDLE:
  - start=1 triggers a load event; otherwise stay in IDLE.
  - start is ignored in SEND and GAPW, with no queuing.
- SEND:
  - Each edge: buffer shifts left 1 and bcnt increments.
  - Link carries start, a1, a0, d3, d2, d1, d0 on bcnt = 1..7.
- End of packet, at the edge leaving bcnt==7:
  - pcnt==4: phase <= IDLE, pcnt <= 0, done <= 1.
  - pcnt<4 and GAP==0: load event. The next start bit follows the previous d0 with no dead cycle, as the receivers accept a start bit in their last-bit state.
  - pcnt<4 and GAP>0: phase <= GAPW with link=0 for exactly GAP cycles. A load event occurs at the edge ending the last gap cycle.
- done is high for exactly one cycle, the first IDLE cycle after the sweep.
  - start=1 in that same cycle is accepted, giving back-to-back sweeps.
- Latency:
  - start sampled at edge E0; link carries the first start bit in the cycle after E0.
  - A sweep occupies 28 + 3*GAP link cycles; done is in the next cycle.
- No transmission outside a sweep: link stays 0 in IDLE, so stray start bits never appear.

Test Plan:
- Regs {0:5, 1:A, 2:F, 3:0}, GAP=0, pulse start -> link = 1000101 1011010 1101111 1110000 over cycles 1..28; done=1 only in cycle 29; busy 1 over cycles 1..28. Loopback into the register-file receiver yields an identical copy.
- Same regs, GAP=2 -> two 0 cycles after each of packets 0..2; 34 link cycles; done in cycle 35; rfaddr steps 0,1,2,3,0.
- start re-pulsed at cycles 5 and 20 of a sweep -> ignored; exactly one done; link pattern unchanged.
- clear at bcnt=4 of packet 1 -> link=0, busy=0, rfaddr=0 next cycle; no done. A subsequent start resends from register 0 with a full 28-cycle sweep.
- Write reg0=3 in cycle 2 (after reg0 loaded) and reg2=9 in cycle 2 -> packet 0 carries old 5; packet 2 carries 9.
- start held high for 70 cycles -> sweeps back-to-back; done pulses in cycles 29 and 58; second sweep's first start bit in cycle 30.
